tube_event_builder: RTL and testbench
=====================================

# tube_event_builder

Parametrised successor to the fixed 32-tube readout path. On a synchronised scintillator coincidence it opens a timing window. It records the first rising edge of each of NUM_TUBES tube discriminator inputs as a clock-cycle timestamp. It then serialises the event as {time, tube id} words plus a trailer into an internal show-ahead FIFO that the RPi drains. Whole events are dropped (never truncated) when the FIFO lacks room, and a hold-off follows every event.

## Interface
- NUM_TUBES, 32, number of tube channels; must be < 2^ID_W − 1
- TIME_W, 8, timestamp field width
- ID_W, 8, tube id field width; word width is TIME_W+ID_W
- WINDOW, 255, window length in cycles; must be ≤ 2^TIME_W − 1
- HOLDOFF, 16, dead cycles after each event, ≥ 1
- FIFO_DEPTH, 64, output FIFO words; power of two, ≥ NUM_TUBES+1
- clk50  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- scin_coin  in  1  scintillator coincidence, asynchronous
- tube_in  in  NUM_TUBES  tube discriminator pins, asynchronous
- rd_data  out  TIME_W+ID_W  FIFO head word (show-ahead)
- rd_valid  out  1  FIFO non-empty
- rd_en  in  1  pop head; ignored when rd_valid=0
- busy  out  1  state ≠ IDLE
- overflow  out  1  sticky: at least one event dropped
- drop_cnt  out  8  dropped events, saturates at 255

## Operation
- scin_coin and each tube_in pass through 2-FF synchronisers, then a 1-FF edge detector (rise = s & ~s_d). Both paths have equal latency.
- IDLE: on coin rise, clear all hit flags, set tcnt=0, go to WIN.
- WIN: for each tube with a rise and hit=0, set hit=1 and time=tcnt. Later edges on that tube are ignored. tcnt increments each cycle. When tcnt==WINDOW−1 (edges that cycle still count), go to CHK. Coin rises are ignored.
- CHK (1 cycle): need = NUM_TUBES+1 (macro off) or popcount(hit)+1 (macro on). If free entries ≥ need, go to DRN with i=0. Otherwise increment drop_cnt, set overflow, and go to HOLD.
- DRN: one channel per cycle, i=0..NUM_TUBES−1. A word {time_i, i} is written for a hit channel. A non-hit channel either writes {all-ones, i} (macro off) or writes nothing (macro on). After i=NUM_TUBES−1, go to TRL.
- TRL: write the all-ones trailer word, go to HOLD.
- HOLD: wait HOLDOFF cycles, then go to IDLE. Coin rises in HOLD are lost and are not counted as drops.
- FIFO: write never blocks, because space is guaranteed by CHK. A simultaneous read and write is legal at any fill level. rd_en with rd_valid=0 has no effect.
- Reset values: state IDLE; FIFO empty, so rd_valid=0 and rd_data=0; busy=0; overflow=0; drop_cnt=0. Reset mid-event discards the partial event and all FIFO contents.

## Timing
- Coin rise is detected 3 cycles after the pin edge. WIN starts on the following cycle with tcnt=0.
- A tube pin edge d cycles after the coin pin edge records time d−1 for 1 ≤ d ≤ WINDOW. d ≤ 0 or d > WINDOW gives no hit.
- A tube already high at window start records no hit unless it falls and rises again inside the window.
- Event length: 1 (IDLE) + WINDOW + 1 (CHK) + NUM_TUBES (DRN) + 1 (TRL) + HOLDOFF cycles.
- The first word appears on rd_data with rd_valid=1 one cycle after its write cycle.
- rd_en pops on the clock edge; the next word is on rd_data in the following cycle.

## Configuration
- ZERO_SUPPRESS_EN defined: non-hit channels are skipped, and an event is popcount(hit)+1 words.
- ZERO_SUPPRESS_EN undefined: every channel emits a word, with no-hit time all ones. An event is always NUM_TUBES+1 words, matching the legacy fixed-format stream.

## Test plan
- Macro off, defaults. Coin edge, then tube 5 edge 11 cycles later and tube 31 edge 200 cycles later. Required: 33 words, 0x0A05 at position 5, 0xC71F at position 31, all others 0xFFii, trailer 0xFFFF.
- Macro on. Same stimulus. Required: exactly 0x0A05, 0xC71F, 0xFFFF.
- Tube 3 pulses at d=4, then again at d=50. Required: time 3 recorded; second edge ignored. A tube edge at d=256 gives no hit.
- Fill the FIFO to 40 without reading, then trigger with macro off. Required: no words written, drop_cnt=1, overflow=1. Then read 20 words and retrigger; the event is accepted.
- Second coin rise 5 cycles into HOLD. Required: ignored, drop_cnt unchanged. A coin rise after busy falls starts a new event.
- Assert rst_n low mid-DRN with 10 words queued. Required: rd_valid=0 immediately; after release, busy=0, drop_cnt=0, overflow=0.

Source files
------------

// File: rtl/tube_event_builder.sv
// tube_event_builder
// Scintillator-triggered event builder for NUM_TUBES tube discriminator inputs.
// A coincidence opens a WINDOW-cycle timing window. The first rising edge on
// each tube is timestamped, and the event is serialised as {time, tube id}
// words plus an all-ones trailer into a show-ahead FIFO.
// Whole events are dropped when the FIFO cannot hold them.
//
// Build option: define ZERO_SUPPRESS_EN to emit only hit channels.
// Undefined (the default), every channel emits a word and a missing hit
// carries an all-ones time, as in the legacy fixed-format stream.
//
// state | meaning
// IDLE  | waiting for a coincidence rise
// WIN   | timing window open, tcnt counts 0..WINDOW-1
// CHK   | decide whether the whole event fits in the FIFO
// DRN   | one channel per cycle into the FIFO
// TRL   | trailer word
// HOLD  | HOLDOFF dead cycles, coincidences ignored

module tube_event_builder #(
  parameter int NUM_TUBES  = 32,
  parameter int TIME_W     = 8,
  parameter int ID_W       = 8,
  parameter int WINDOW     = 255,
  parameter int HOLDOFF    = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  input  logic                   scin_coin,
  input  logic [NUM_TUBES-1:0]   tube_in,
  output logic [TIME_W+ID_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_en,
  output logic                   busy,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int W  = TIME_W + ID_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NUM_TUBES > 1) ? $clog2(NUM_TUBES) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN,
    S_CHK,
    S_DRN,
    S_TRL,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and rise detectors (same latency on coin and tubes)
  // ---------------------------------------------------------------------------
  logic                 coin_m, coin_s, coin_d;
  logic [NUM_TUBES-1:0] tube_m, tube_s, tube_d;
  logic                 coin_rise;
  logic [NUM_TUBES-1:0] tube_rise;

  // Two-flop synchroniser followed by a one-flop delay for edge detection
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      coin_m <= 1'b0;
      coin_s <= 1'b0;
      coin_d <= 1'b0;
      tube_m <= '0;
      tube_s <= '0;
      tube_d <= '0;
    end else begin
      coin_m <= scin_coin;
      coin_s <= coin_m;
      coin_d <= coin_s;
      tube_m <= tube_in;
      tube_s <= tube_m;
      tube_d <= tube_s;
    end
  end

  assign coin_rise = coin_s & ~coin_d;
  assign tube_rise = tube_s & ~tube_d;

  // ---------------------------------------------------------------------------
  // Output FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          do_rd;

  assign do_rd    = rd_en && (count != '0);
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk50) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and fill-level bookkeeping; reads and writes may coincide
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FSM
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [TIME_W-1:0]    tcnt;
  logic [NUM_TUBES-1:0] hit;
  logic [TIME_W-1:0]    times [NUM_TUBES];
  logic [IW-1:0]        ch;
  logic [HW-1:0]        hcnt;
  logic                 busy_r;
  logic                 overflow_r;
  logic [7:0]           drop_cnt_r;
  logic [CW:0]          free_cnt;
  logic [CW:0]          need_cnt;

`ifdef ZERO_SUPPRESS_EN
  function automatic logic [IW:0] popcnt(input logic [NUM_TUBES-1:0] v);
    logic [IW:0] n;
    n = '0;
    for (int k = 0; k < NUM_TUBES; k++) n = n + (IW+1)'(v[k]);
    return n;
  endfunction

  assign need_cnt = (CW+1)'(popcnt(hit)) + (CW+1)'(1);
`else
  assign need_cnt = (CW+1)'(NUM_TUBES + 1);
`endif

  assign free_cnt = (CW+1)'(FIFO_DEPTH) - {1'b0, count};

  // FIFO write decode: one channel word per DRN cycle, trailer in TRL
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (state == S_DRN) begin
      if (hit[ch]) begin
        wr_en   = 1'b1;
        wr_data = {times[ch], ID_W'(ch)};
      end else begin
`ifdef ZERO_SUPPRESS_EN
        wr_en   = 1'b0;
`else
        wr_en   = 1'b1;
        wr_data = {{TIME_W{1'b1}}, ID_W'(ch)};
`endif
      end
    end else if (state == S_TRL) begin
      wr_en   = 1'b1;
      wr_data = '1;
    end
  end

  // Sequencing: window timing, capacity check, drain, trailer and hold-off
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      hit        <= '0;
      times      <= '{default: '0};
      ch         <= '0;
      hcnt       <= '0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (coin_rise) begin
            hit    <= '0;
            tcnt   <= '0;
            busy_r <= 1'b1;
            state  <= S_WIN;
          end
        end
        S_WIN: begin
          for (int k = 0; k < NUM_TUBES; k++) begin
            if (tube_rise[k] && !hit[k]) begin
              hit[k]   <= 1'b1;
              times[k] <= tcnt;
            end
          end
          if (tcnt == TIME_W'(WINDOW - 1)) state <= S_CHK;
          else                             tcnt  <= tcnt + 1'b1;
        end
        S_CHK: begin
          if (free_cnt >= need_cnt) begin
            ch    <= '0;
            state <= S_DRN;
          end else begin
            if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
            overflow_r <= 1'b1;
            hcnt       <= HW'(HOLDOFF - 1);
            state      <= S_HOLD;
          end
        end
        S_DRN: begin
          if (ch == IW'(NUM_TUBES - 1)) state <= S_TRL;
          else                          ch    <= ch + 1'b1;
        end
        S_TRL: begin
          hcnt  <= HW'(HOLDOFF - 1);
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (hcnt == '0) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            hcnt <= hcnt - 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_tube_event_builder.sv
// Testbench for tube_event_builder. Stimulus pushes the expected word stream
// into a queue; an independent reader/monitor pops and compares on each read.
module tb_tube_event_builder;

  localparam int NT     = 32;
  localparam int TW     = 8;
  localparam int IDW    = 8;
  localparam int W      = TW + IDW;
  localparam int WINDOW = 255;

  logic          clk50 = 1'b0;
  logic          rst_n;
  logic          scin_coin;
  logic [NT-1:0] tube_in;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          rd_en;
  logic          busy;
  logic          overflow;
  logic [7:0]    drop_cnt;

  tube_event_builder dut (
    .clk50    (clk50),
    .rst_n    (rst_n),
    .scin_coin(scin_coin),
    .tube_in  (tube_in),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_en    (rd_en),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #10 clk50 = ~clk50;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int           reads_left = 0;
  int           p_tube[$];
  int           p_d[$];
  int           coin2 = -1;
  int           exp_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reader and monitor: requests reads while reads_left > 0, checks each popped head
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge clk50);
      rd_en = (reads_left > 0);
      if (rd_en && rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", rd_data);
        end else begin
          check("rd_word", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        reads_left--;
      end
    end
  end

  // Expected stream from the pulse table: first edge at 1<=d<=WINDOW gives time d-1
  task automatic push_expected();
    logic [TW-1:0] t [NT];
    logic          h [NT];
    for (int k = 0; k < NT; k++) begin
      h[k] = 1'b0;
      t[k] = '0;
    end
    for (int j = 0; j < p_tube.size(); j++) begin
      if (p_d[j] >= 1 && p_d[j] <= WINDOW) begin
        if (!h[p_tube[j]] || TW'(p_d[j] - 1) < t[p_tube[j]]) begin
          h[p_tube[j]] = 1'b1;
          t[p_tube[j]] = TW'(p_d[j] - 1);
        end
      end
    end
    for (int k = 0; k < NT; k++) begin
      if (h[k]) exp_q.push_back({t[k], IDW'(k)});
`ifndef ZERO_SUPPRESS_EN
      else      exp_q.push_back({{TW{1'b1}}, IDW'(k)});
`endif
    end
    exp_q.push_back({W{1'b1}});
  endtask

  // Drive coin at c=0 (and optionally at coin2), tube pulses of width 2 at c=d
  task automatic drive_event(input int ncyc, input bit chk_start, input int fall_c);
    logic [NT-1:0] tv;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk50);
      if (chk_start && c == 2) check("busy_pre", 32'(busy), 32'd0);
      if (chk_start && c == 3) check("busy_start", 32'(busy), 32'd1);
      if (fall_c >= 0 && c == fall_c - 1) check("busy_before_end", 32'(busy), 32'd1);
      if (fall_c >= 0 && c == fall_c) check("busy_end", 32'(busy), 32'd0);
      scin_coin = (c < 2) || (coin2 >= 0 && c >= coin2 && c < coin2 + 2);
      tv = '0;
      for (int j = 0; j < p_tube.size(); j++)
        if (c >= p_d[j] && c < p_d[j] + 2) tv[p_tube[j]] = 1'b1;
      tube_in = tv;
    end
    @(negedge clk50);
    scin_coin = 1'b0;
    tube_in   = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      @(negedge clk50);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic set_reads(input int n);
    @(posedge clk50);
    #1;
    reads_left = n;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (reads_left == 0) break;
      @(negedge clk50);
    end
    check("drain_timeout", 32'(reads_left), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    scin_coin = 1'b0;
    tube_in   = '0;
    repeat (3) @(negedge clk50);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50);

    // Basic event: tube 5 at d=11, tube 31 at d=200; also checks event length
    p_tube = {5, 31};
    p_d    = {11, 200};
    push_expected();
    set_reads(exp_q.size());
    drive_event(310, 1'b1, 308);
    wait_idle();
    wait_drain();

    // Repeated edge, window boundaries d=1 and d=WINDOW, late edge d=256
    p_tube = {3, 3, 0, 1, 7};
    p_d    = {4, 50, 255, 1, 256};
    push_expected();
    set_reads(exp_q.size());
    drive_event(262, 1'b1, -1);
    wait_idle();
    wait_drain();

`ifndef ZERO_SUPPRESS_EN
    // Fill to 40 words: full event, read 26, another full event
    p_tube = {};
    p_d    = {};
    push_expected();
    drive_event(262, 1'b1, -1);
    wait_idle();
    set_reads(26);
    wait_drain();
    p_tube = {9};
    p_d    = {100};
    push_expected();
    drive_event(262, 1'b1, -1);
    wait_idle();
    check("fill_valid", 32'(rd_valid), 32'd1);

    // 24 free < 33 needed: whole event dropped, shorter hold-off path
    p_tube = {2};
    p_d    = {20};
    drive_event(280, 1'b1, 275);
    wait_idle();
    exp_drops = 1;
    check("drop_cnt_after_drop", 32'(drop_cnt), 32'(exp_drops));
    check("overflow_after_drop", 32'(overflow), 32'd1);

    // Read 20 words leaving 20 queued; the next event fits
    set_reads(20);
    wait_drain();
    p_tube = {12};
    p_d    = {30};
    push_expected();
    drive_event(262, 1'b1, -1);
    wait_idle();
    check("drop_cnt_accept", 32'(drop_cnt), 32'(exp_drops));
    set_reads(exp_q.size());
    wait_drain();
`endif

    // Coin rise 5 cycles into HOLD is ignored
    p_tube = {20};
    p_d    = {60};
    coin2  = 295;
    push_expected();
    set_reads(exp_q.size());
    drive_event(310, 1'b1, 308);
    coin2 = -1;
    wait_idle();
    wait_drain();
    check("drop_cnt_hold", 32'(drop_cnt), 32'(exp_drops));

    // A coin after busy falls starts a new event
    p_tube = {1};
    p_d    = {2};
    push_expected();
    set_reads(exp_q.size());
    drive_event(262, 1'b1, -1);
    wait_idle();
    wait_drain();

    // Reset in the middle of DRN with words queued
    p_tube = {4, 6, 8};
    p_d    = {10, 3, 1};
    drive_event(268, 1'b1, -1);
    check("pre_reset_valid", 32'(rd_valid), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    repeat (2) @(negedge clk50);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_drop_cnt", 32'(drop_cnt), 32'd0);
    check("post_reset_overflow", 32'(overflow), 32'd0);
    repeat (40) @(negedge clk50);
    check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
